// File: rtl/b_io_l3_in_serialize_b_m_axi_burst_split_pkg.sv
// Shared m_axi constants for the B_IO_L3 input serializer read path.
//   M_AXI_BOUNDARY_BYTES / _LOG2 : AXI bursts may not cross this byte boundary
//   M_AXI_LEN_W                  : width of AXI ARLEN (burst beats minus one)
//   split_state_e                : burst splitter FSM states
package b_io_l3_in_serialize_b_m_axi_burst_split_pkg;

  localparam int unsigned M_AXI_BOUNDARY_BYTES = 4096;
  localparam int unsigned M_AXI_BOUNDARY_LOG2  = 12;
  localparam int unsigned M_AXI_LEN_W          = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

endpackage

// File: rtl/b_io_l3_in_serialize_b_m_axi_burst_split.sv
// Splits a (start address, beat count) read request into AXI bursts that
// never exceed MAX_BURST_LEN beats and never cross a 4 KB boundary. One
// burst is offered per cycle while out_ready stays high.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   clk_en          : global enable; low freezes all state
//   req_valid/ready : request handshake (ready only while idle)
//   req_addr        : start byte address, beat aligned
//   req_len         : total beats (0 = request is dropped)
//   out_valid/ready : burst handshake towards the downstream request FIFO
//   out_addr        : burst start byte address
//   out_len         : AXI ARLEN (beats minus one)
module b_io_l3_in_serialize_b_m_axi_burst_split
  import b_io_l3_in_serialize_b_m_axi_burst_split_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int LEN_WIDTH     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [LEN_WIDTH-1:0]   req_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [M_AXI_LEN_W-1:0] out_len
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int B4K_W      = M_AXI_BOUNDARY_LOG2 + 1;
  localparam int BEATS_W    = M_AXI_LEN_W + 1;
  localparam int CW         = (LEN_WIDTH > B4K_W) ? LEN_WIDTH : B4K_W;

  // Beats in the next burst: min(remaining, MAX_BURST_LEN, beats to 4 KB).
  // The address is beat aligned, so the shift is an exact division.
  function automatic logic [BEATS_W-1:0] burst_beats(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [LEN_WIDTH-1:0]  rem
  );
    logic [B4K_W-1:0] to_4k;
    logic [CW-1:0]    b;
    to_4k = (B4K_W'(M_AXI_BOUNDARY_BYTES) - {1'b0, a[M_AXI_BOUNDARY_LOG2-1:0]}) >> BYTE_SHIFT;
    b = CW'(rem);
    if (b > CW'(MAX_BURST_LEN)) b = CW'(MAX_BURST_LEN);
    if (b > CW'(to_4k))         b = CW'(to_4k);
    return b[BEATS_W-1:0];
  endfunction

  split_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0]  addr_p0;
  logic [LEN_WIDTH-1:0]   rem_p0;
  logic [M_AXI_LEN_W-1:0] len_p0;

  logic                   req_fire;
  logic                   out_fire;
  logic                   req_nonzero;
  logic [BEATS_W-1:0]     cur_beats;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic [LEN_WIDTH-1:0]   next_rem;
  logic [BEATS_W-1:0]     first_len;
  logic [BEATS_W-1:0]     follow_len;

  assign req_ready   = (state == ST_IDLE);
  assign out_valid   = (state == ST_SPLIT);
  assign out_addr    = addr_p0;
  assign out_len     = len_p0;

  assign req_fire    = clk_en & req_valid & req_ready;
  assign out_fire    = clk_en & out_valid & out_ready;
  assign req_nonzero = (req_len != '0);

  // The burst on the bus is always len_p0+1 beats; it can never exceed rem_p0.
  assign cur_beats   = {1'b0, len_p0} + BEATS_W'(1);
  assign next_addr   = addr_p0 + (ADDR_WIDTH'(cur_beats) << BYTE_SHIFT);
  assign next_rem    = rem_p0 - LEN_WIDTH'(cur_beats);
  assign first_len   = burst_beats(req_addr, req_len) - BEATS_W'(1);
  assign follow_len  = burst_beats(next_addr, next_rem) - BEATS_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_fire && req_nonzero) state_nxt = ST_SPLIT;
      ST_SPLIT: if (out_fire && (next_rem == '0)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---- p0: registered burst presented on out_addr / out_len ----
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_p0 <= '0;
      rem_p0  <= '0;
      len_p0  <= '0;
    end else if (clk_en) begin
      if (req_fire && req_nonzero) begin
        addr_p0 <= req_addr;
        rem_p0  <= req_len;
        len_p0  <= first_len[M_AXI_LEN_W-1:0];
      end else if (out_fire) begin
        addr_p0 <= next_addr;
        rem_p0  <= next_rem;
        // On the final burst the length is left as is; nothing reads it in idle.
        if (next_rem != '0) len_p0 <= follow_len[M_AXI_LEN_W-1:0];
      end
    end
  end

endmodule
